// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, funct and ALU control-code definitions for the
// MIPS execute-stage ALU (alu32_bit) and its adder sub-block.
package alu_pkg;

   // main-control ALU opcodes
   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
   localparam logic [3:0] ALUOP_AND   = 4'b0011;
   localparam logic [3:0] ALUOP_OR    = 4'b0100;
   localparam logic [3:0] ALUOP_XOR   = 4'b0101;
   localparam logic [3:0] ALUOP_SLT   = 4'b0110;
   localparam logic [3:0] ALUOP_SLTU  = 4'b0111;
   localparam logic [3:0] ALUOP_LUI   = 4'b1000;

   // R-type funct field values
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;

   // decoded ALU control code
   typedef enum logic [3:0] {
      CTL_AND  = 4'b0000, CTL_OR   = 4'b0001, CTL_ADD  = 4'b0010, CTL_XOR  = 4'b0011,
      CTL_ADDU = 4'b0100, CTL_SUBU = 4'b0101, CTL_SUB  = 4'b0110, CTL_SLT  = 4'b0111,
      CTL_SLL  = 4'b1000, CTL_SRL  = 4'b1001, CTL_SRA  = 4'b1010, CTL_SLTU = 4'b1011,
      CTL_NOR  = 4'b1100, CTL_LUI  = 4'b1101, CTL_SLLV = 4'b1110, CTL_SRLV = 4'b1111
   } alu_ctl_t;

endpackage

// File: rtl/alu_adder32.sv
// alu_adder32: ripple-free behavioural adder with carry-in, carry-out and
// two's-complement overflow. Used for the main ALU and the address adder.
module alu_adder32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

   // overflow when both addends share a sign that the sum does not
   assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu32_bit.sv
// alu32_bit: MIPS EX-stage ALU. Decodes alu_op/funct to an ALU control code,
// produces result/zero/overflow combinationally, keeps a sticky overflow bit,
// and provides an independent address adder.
// Optional: define ALU_VAR_SHIFT_EN to enable SLLV/SRLV (shift by a[4:0]).
module alu32_bit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [4:0]       shamt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [3:0]       alu_ctl,
   output logic             ovf_sticky,
   input  logic [WIDTH-1:0] add_a,
   input  logic [WIDTH-1:0] add_b,
   output logic [WIDTH-1:0] add_sum
);

   alu_ctl_t         ctl;
   logic             sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             add_ovf;
   logic             slt;
   logic             sltu;
   logic             addr_cout_unused;
   logic             addr_ovf_unused;

   // control decode: alu_op selects directly, 0010 defers to funct
   always_comb begin
      ctl = CTL_ADDU;
      case (alu_op)
         ALUOP_ADD:  ctl = CTL_ADD;
         ALUOP_SUB:  ctl = CTL_SUB;
         ALUOP_AND:  ctl = CTL_AND;
         ALUOP_OR:   ctl = CTL_OR;
         ALUOP_XOR:  ctl = CTL_XOR;
         ALUOP_SLT:  ctl = CTL_SLT;
         ALUOP_SLTU: ctl = CTL_SLTU;
         ALUOP_LUI:  ctl = CTL_LUI;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD:  ctl = CTL_ADD;
               FUNCT_ADDU: ctl = CTL_ADDU;
               FUNCT_SUB:  ctl = CTL_SUB;
               FUNCT_SUBU: ctl = CTL_SUBU;
               FUNCT_AND:  ctl = CTL_AND;
               FUNCT_OR:   ctl = CTL_OR;
               FUNCT_XOR:  ctl = CTL_XOR;
               FUNCT_NOR:  ctl = CTL_NOR;
               FUNCT_SLT:  ctl = CTL_SLT;
               FUNCT_SLTU: ctl = CTL_SLTU;
               FUNCT_SLL:  ctl = CTL_SLL;
               FUNCT_SRL:  ctl = CTL_SRL;
               FUNCT_SRA:  ctl = CTL_SRA;
`ifdef ALU_VAR_SHIFT_EN
               FUNCT_SLLV: ctl = CTL_SLLV;
               FUNCT_SRLV: ctl = CTL_SRLV;
`endif
               default:    ctl = CTL_ADDU;
            endcase
         end
         default:    ctl = CTL_ADDU;
      endcase
   end

   assign alu_ctl = ctl;

   // subtract and both compares share the adder as a + ~b + 1
   assign sub  = (ctl == CTL_SUB) || (ctl == CTL_SUBU) || (ctl == CTL_SLT) || (ctl == CTL_SLTU);
   assign b_op = sub ? ~b : b;

   alu_adder32 #(.WIDTH(WIDTH)) u_alu_add (
      .a        (a),
      .b        (b_op),
      .cin      (sub),
      .sum      (sum),
      .cout     (cout),
      .overflow (add_ovf)
   );

   // signed less-than corrects the difference sign by overflow;
   // unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1
   assign slt  = sum[WIDTH-1] ^ add_ovf;
   assign sltu = ~cout;

   // result mux over all control codes
   always_comb begin
      result = '0;
      case (ctl)
         CTL_AND:  result = a & b;
         CTL_OR:   result = a | b;
         CTL_XOR:  result = a ^ b;
         CTL_NOR:  result = ~(a | b);
         CTL_ADD, CTL_ADDU, CTL_SUB, CTL_SUBU: result = sum;
         CTL_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
         CTL_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
         CTL_SLL:  result = b << shamt;
         CTL_SRL:  result = b >> shamt;
         CTL_SRA:  result = $signed(b) >>> shamt;
         CTL_LUI:  result = {b[15:0], 16'h0000};
`ifdef ALU_VAR_SHIFT_EN
         CTL_SLLV: result = b << a[4:0];
         CTL_SRLV: result = b >> a[4:0];
`else
         CTL_SLLV, CTL_SRLV: result = '0;
`endif
         default:  result = '0;
      endcase
   end

   assign zero     = (result == '0);
   assign overflow = ((ctl == CTL_ADD) || (ctl == CTL_SUB)) && add_ovf;

   // address adder: PC+4 / branch target, wraps with no flags
   alu_adder32 #(.WIDTH(WIDTH)) u_addr_add (
      .a        (add_a),
      .b        (add_b),
      .cin      (1'b0),
      .sum      (add_sum),
      .cout     (addr_cout_unused),
      .overflow (addr_ovf_unused)
   );

   // sticky overflow status; reset has priority over a same-cycle overflow
   always_ff @(posedge clk) begin
      if (!reset) ovf_sticky <= 1'b0;
      else        ovf_sticky <= ovf_sticky | overflow;
   end

endmodule

// File: tb/tb_alu32_bit.sv
// tb_alu32_bit: scoreboard bench for alu32_bit. Each driven vector pushes a
// reference-model expectation; the negedge monitor pops and compares.
module tb_alu32_bit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a, b, add_a, add_b;
   logic [31:0] result, add_sum;
   logic        zero, overflow, ovf_sticky;
   logic [3:0]  alu_ctl;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  c;
      logic        z;
      logic        o;
      logic        st;
      logic [31:0] s;
   } exp_t;

   exp_t q[$];

   logic m_sticky = 1'b0;
   logic prev_rst = 1'b0;
   logic prev_ovf = 1'b0;

   always #5 clk = ~clk;

   alu32_bit dut (
      .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
      .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
      .alu_ctl(alu_ctl), .ovf_sticky(ovf_sticky),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference: spec decode tables, then behavioural arithmetic on wide ints
   function automatic void model(input logic [3:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [31:0] x,
                                 input logic [31:0] y, output logic [31:0] r,
                                 output logic [3:0] c, output logic o);
      longint sx, sy, t;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      o  = 1'b0;
      case (op)
         4'b0000: c = 4'b0010;
         4'b0001: c = 4'b0110;
         4'b0011: c = 4'b0000;
         4'b0100: c = 4'b0001;
         4'b0101: c = 4'b0011;
         4'b0110: c = 4'b0111;
         4'b0111: c = 4'b1011;
         4'b1000: c = 4'b1101;
         4'b0010: begin
            case (fn)
               6'b100000: c = 4'b0010;
               6'b100001: c = 4'b0100;
               6'b100010: c = 4'b0110;
               6'b100011: c = 4'b0101;
               6'b100100: c = 4'b0000;
               6'b100101: c = 4'b0001;
               6'b100110: c = 4'b0011;
               6'b100111: c = 4'b1100;
               6'b101010: c = 4'b0111;
               6'b101011: c = 4'b1011;
               6'b000000: c = 4'b1000;
               6'b000010: c = 4'b1001;
               6'b000011: c = 4'b1010;
`ifdef ALU_VAR_SHIFT_EN
               6'b000100: c = 4'b1110;
               6'b000110: c = 4'b1111;
`endif
               default:   c = 4'b0100;
            endcase
         end
         default: c = 4'b0100;
      endcase
      r = 32'h0;
      case (c)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0011: r = x ^ y;
         4'b1100: r = ~(x | y);
         4'b0010: begin t = sx + sy; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'b0100: r = x + y;
         4'b0110: begin t = sx - sy; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'b0101: r = x - y;
         4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
         4'b1011: r = (x < y) ? 32'd1 : 32'd0;
         4'b1000: r = y << sh;
         4'b1001: r = y >> sh;
         4'b1010: begin t = sy >>> sh; r = t[31:0]; end
         4'b1101: r = {y[15:0], 16'h0};
`ifdef ALU_VAR_SHIFT_EN
         4'b1110: r = y << x[4:0];
         4'b1111: r = y >> x[4:0];
`endif
         default: r = 32'h0;
      endcase
   endfunction

   // drive one vector just after a rising edge and queue its expectation
   task automatic drive(input logic rst, input logic [3:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] aa, input logic [31:0] ab);
      exp_t e;
      @(posedge clk);
      // sticky update at this edge used the previous vector
      m_sticky = prev_rst ? (m_sticky | prev_ovf) : 1'b0;
      #1;
      reset = rst; alu_op = op; funct = fn; shamt = sh; a = x; b = y; add_a = aa; add_b = ab;
      model(op, fn, sh, x, y, e.r, e.c, e.o);
      e.z  = (e.r == 32'h0);
      e.st = m_sticky;
      e.s  = aa + ab;
      q.push_back(e);
      prev_rst = rst;
      prev_ovf = e.o;
   endtask

   // monitor: compare every queued expectation at the falling edge
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("result",     result,            e.r);
         chk("zero",       {31'b0, zero},     {31'b0, e.z});
         chk("overflow",   {31'b0, overflow}, {31'b0, e.o});
         chk("alu_ctl",    {28'b0, alu_ctl},  {28'b0, e.c});
         chk("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, e.st});
         chk("add_sum",    add_sum,           e.s);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] fl [0:16];
      fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
             6'b000011, 6'b000100, 6'b000110, 6'b111111, 6'b010101};
      reset = 1'b0; alu_op = 4'h0; funct = 6'h0; shamt = 5'h0;
      a = 32'h0; b = 32'h0; add_a = 32'h0; add_b = 32'h0;

      // in reset: comb outputs live, sticky cleared
      drive(1'b0, 4'b0000, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      // ADD overflow, sticky sets, then reset clears
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h00400000, 32'h4);
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h1, 32'h1, 32'hFFFFFFFC, 32'h4);
      drive(1'b0, 4'b0000, 6'h0, 5'd0, 32'h1, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h1, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      // reset wins over same-cycle overflow
      drive(1'b0, 4'b0001, 6'h0, 5'd0, 32'h80000000, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0000, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      // SUBU / SUB equal operands
      drive(1'b1, 4'b0010, 6'b100011, 5'd0, 32'h5, 32'h5, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b100010, 5'd0, 32'h5, 32'h5, 32'h0, 32'h0);
      // SLT vs SLTU
      drive(1'b1, 4'b0010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
      // shifts
      drive(1'b1, 4'b0010, 6'b000011, 5'd4, 32'h0, 32'hF0000000, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b000010, 5'd4, 32'h0, 32'hF0000000, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b000000, 5'd31, 32'h0, 32'h00000003, 32'h0, 32'h0);
      // LUI, ADDU default opcode, NOR
      drive(1'b1, 4'b1000, 6'h0, 5'd0, 32'h0, 32'h00001234, 32'h0, 32'h0);
      drive(1'b1, 4'b1111, 6'h0, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b100111, 5'd0, 32'h0F0F0000, 32'h000000F0, 32'h0, 32'h0);
      // SUB overflow (neg - pos)
      drive(1'b1, 4'b0001, 6'h0, 5'd0, 32'h80000000, 32'h1, 32'h0, 32'h0);
      // variable shifts (ADDU when feature is off)
      drive(1'b1, 4'b0010, 6'b000100, 5'd0, 32'h3, 32'h1, 32'h0, 32'h0);
      drive(1'b1, 4'b0010, 6'b000110, 5'd0, 32'h4, 32'h80000000, 32'h0, 32'h0);
      // random mix
      for (int i = 0; i < 60; i++) begin
         drive(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)),
               fl[$urandom_range(0, 16)], 5'($urandom), $urandom, $urandom,
               $urandom, $urandom);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      chk("drain", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu32_bit.md
Name: alu32_bit

Overview:
- Execute-stage arithmetic block of the 5-stage MIPS pipeline.
- Decodes the 4-bit main-control ALU opcode plus the R-type funct field into a 4-bit ALU control code.
- Computes the 32-bit result with zero and signed-overflow flags.
- Provides an independent 32-bit address adder for PC+4 and branch-target generation.
- Datapath is combinational and evaluates within the EX cycle. The only state is a sticky overflow status bit.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- alu_op  in  4  ALU opcode from main control
- funct  in  6  instruction[5:0], used when alu_op=0010
- shamt  in  5  instruction[10:6]
- a  in  32  operand A (rs, forwarded)
- b  in  32  operand B (rt or sign-extended immediate)
- result  out  32  ALU result
- zero  out  1  result==0
- overflow  out  1  signed overflow of ADD/SUB
- alu_ctl  out  4  decoded control code, for debug and verification
- ovf_sticky  out  1  registered OR of overflow since reset
- add_a  in  32  address adder input A
- add_b  in  32  address adder input B
- add_sum  out  32  add_a+add_b mod 2^32, no flags

Behaviour:
- alu_op decode:
  - 0000 ADD
  - 0001 SUB
  - 0010 use funct
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 SLT
  - 0111 SLTU
  - 1000 LUI
  - any other value ADDU
- funct decode:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA
  - any other value ADDU
- alu_ctl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 ADDU, 0101 SUBU, 0110 SUB, 0111 SLT
  - 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU
  - 1100 NOR, 1101 LUI, 1110 SLLV, 1111 SRLV
- Operations:
  - ADD/ADDU: a+b. SUB/SUBU: a-b. Both wrap mod 2^32.
  - SLT: signed a<b gives 1, else 0. SLTU: unsigned comparison.
  - SLL/SRL/SRA: b shifted by shamt; SRA replicates b[31].
  - NOR: ~(a|b).
  - LUI: {b[15:0],16'h0000}.
- overflow:
  - ADD: a and b have the same sign and the sum sign differs.
  - SUB: a and b have different signs and the result sign differs from a.
  - All other ops: 0.
- zero = (result==32'h0), computed for every op.
- All outputs except ovf_sticky are combinational, zero latency. No internal pipeline register is allowed.
- ovf_sticky on each rising clk edge:
  - reset=0: cleared to 0.
  - Otherwise: ovf_sticky <= ovf_sticky | overflow.
  - Reset wins when asserted in the same cycle as an overflow.
- During reset: combinational outputs still track their inputs. ovf_sticky reads 0 from the first edge with reset low.
- add_sum wraps silently. Example: FFFFFFFC+4 gives 00000000.

Optional Feature:
- Macro ALU_VAR_SHIFT_EN.
- Defined:
  - funct 000100 decodes to SLLV (1110): result = b << a[4:0].
  - funct 000110 decodes to SRLV (1111): result = b >> a[4:0], logical.
- Undefined:
  - Both functs decode to ADDU. Codes 1110/1111 are unreachable.
  - If forced, codes 1110/1111 produce result 0.

Decomposition:
- Package alu_pkg holds:
  - alu_op localparams (ALUOP_ADD ... ALUOP_LUI)
  - funct localparams (FUNCT_ADD ... FUNCT_SRLV)
  - the 4-bit alu_ctl_t enum with all 16 codes
- Sub-module alu_adder32: 32-bit adder with carry-in, sum, and carry/overflow outputs.
  - Instantiated once for ADD/SUB/SLT, using b inverted with carry-in 1 for subtraction.
  - Instantiated once for add_a+add_b.
- Control decode stays inline as a combinational case statement.

Test Plan:
- alu_op=0000, a=7FFFFFFF, b=1 -> result=80000000, overflow=1, zero=0. Next edge: ovf_sticky=1. Pulse reset=0 for one edge -> ovf_sticky=0.
- alu_op=0010, funct=100011 (SUBU), a=5, b=5 -> result=0, zero=1, overflow=0, alu_ctl=0101. Same operands with funct=100010 (SUB) -> alu_ctl=0110, overflow=0.
- alu_op=0010, funct=101010, a=FFFFFFFF, b=1 -> result=1. funct=101011, same operands -> result=0.
- alu_op=0010, funct=000011, shamt=4, b=F0000000 -> result=FF000000. funct=000010 -> result=0F000000.
- alu_op=1000, b=00001234 -> result=12340000. alu_op=1111 -> ADDU, alu_ctl=0100.
- add_a=00400000, add_b=4 -> add_sum=00400004. add_a=FFFFFFFC, add_b=4 -> add_sum=0. With ALU_VAR_SHIFT_EN defined: funct=000100, a=3, b=1 -> result=8.
